// File: rtl/tone_decoder.sv
// Tone decoder: counts synchronised detector edges per gate window, confirms a run
// of matching windows and classifies the stable count into programmable bands.
module tone_decoder #(
    parameter int                         GATE_CYCLES = 25_000_000,
    parameter int                         CNT_W       = 12,
    parameter int                         CONFIRM     = 3,
    parameter int                         MATCH_TOL   = 25,
    parameter int                         NUM_BANDS   = 3,
    parameter logic [CNT_W*NUM_BANDS-1:0] BAND_LO     = {12'd325, 12'd225, 12'd100},
    parameter logic [CNT_W*NUM_BANDS-1:0] BAND_HI     = {12'd425, 12'd275, 12'd150},
    parameter bit                         STICKY      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mic,
    output logic [2:0]       code,
    output logic             code_valid,
    output logic             locked,
    output logic [CNT_W-1:0] count,
    output logic             window_done
);

    localparam int                GATE_W     = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  TOL_V      = (MATCH_TOL >= (1 << CNT_W)) ? '1 : CNT_W'(MATCH_TOL);
    localparam logic [3:0]        CONFIRM_V  = 4'(CONFIRM);

    typedef struct packed {
        logic              sync1;
        logic              sync2;
        logic              hist;
        logic [GATE_W-1:0] gate;
        logic [CNT_W-1:0]  edges;
        logic [CNT_W-1:0]  prev;
        logic [3:0]        streak;
        logic [CNT_W-1:0]  count;
        logic [2:0]        code;
        logic              code_valid;
        logic              locked;
        logic              window_done;
    } state_t;

    state_t           st_q, st_d;
    logic             rise, close, match, confirm;
    logic [CNT_W-1:0] cur, diff;
    logic [3:0]       streak_next;
    logic [2:0]       band_code;

    assign rise  = st_q.sync2 & ~st_q.hist;
    assign close = (st_q.gate == GATE_LAST);

    // An edge arriving in the close cycle still belongs to the closing window.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        cur         = st_q.edges;
        streak_next = 4'd0;
        if (rise && st_q.edges != CNT_MAX) cur = st_q.edges + CNT_W'(1);
        diff  = (cur >= st_q.prev) ? cur - st_q.prev : st_q.prev - cur;
        match = (diff <= TOL_V);
        if (match) streak_next = (st_q.streak == CONFIRM_V) ? CONFIRM_V : st_q.streak + 4'd1;
        confirm = (streak_next == CONFIRM_V);
    end

    // Scan from the top band down so the lowest matching index wins on overlap.
    always_comb begin
        band_code = 3'd0;
        for (int i = NUM_BANDS - 1; i >= 0; i--) begin
            if (cur >= BAND_LO[i*CNT_W +: CNT_W] && cur <= BAND_HI[i*CNT_W +: CNT_W])
                band_code = 3'(i + 1);
        end
    end

    always_comb begin
        st_d             = st_q;
        st_d.sync1       = mic;
        st_d.sync2       = st_q.sync1;
        st_d.hist        = st_q.sync2;
        st_d.window_done = close;
        st_d.code_valid  = close && confirm;
        if (close) begin
            st_d.gate   = '0;
            st_d.edges  = '0;
            st_d.count  = cur;
            st_d.prev   = cur;
            st_d.streak = streak_next;
            st_d.locked = confirm;
            if (confirm)
                st_d.code = band_code;
            else if (!match && st_q.locked && !STICKY)
                st_d.code = 3'd0;
        end else begin
            st_d.gate  = st_q.gate + GATE_W'(1);
            st_d.edges = cur;
        end
    end

    // NOTE: sequential state uses non-blocking assignment; enable low is a synchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st_q <= '0;
        else if (!enable)
            st_q <= '0;
        else
            st_q <= st_d;
    end

    assign code        = st_q.code;
    assign code_valid  = st_q.code_valid;
    assign locked      = st_q.locked;
    assign count       = st_q.count;
    assign window_done = st_q.window_done;

endmodule

// File: tb/tb_tone_decoder.sv
// Bench for tone_decoder: three instances (sticky, non-sticky, 8-bit count) share
// stimulus; a window-level model predicts count, code, strobes and lock.
module tb_tone_decoder;

    localparam int GATE = 1000;

    logic clk = 1'b0;
    logic reset, enable, mic;

    logic [2:0]  code_a, code_b, code_c;
    logic        cv_a, cv_b, cv_c, lk_a, lk_b, lk_c, wd_a, wd_b, wd_c;
    logic [11:0] count_a, count_b;
    logic [7:0]  count_c;

    tone_decoder #(.GATE_CYCLES(GATE)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .mic(mic),
        .code(code_a), .code_valid(cv_a), .locked(lk_a), .count(count_a), .window_done(wd_a));

    tone_decoder #(.GATE_CYCLES(GATE), .STICKY(1'b0)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .mic(mic),
        .code(code_b), .code_valid(cv_b), .locked(lk_b), .count(count_b), .window_done(wd_b));

    tone_decoder #(.GATE_CYCLES(GATE), .CNT_W(8),
                   .BAND_LO({8'd200, 8'd120, 8'd60}), .BAND_HI({8'd255, 8'd180, 8'd100})) u_c (
        .clk(clk), .reset(reset), .enable(enable), .mic(mic),
        .code(code_c), .code_valid(cv_c), .locked(lk_c), .count(count_c), .window_done(wd_c));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int k;
    int plan_n [256];
    int plan_x [256];

    // Window-level reference model, one entry per instance.
    int m_prev [3], m_streak [3], m_code [3], m_count [3];
    bit m_valid [3], m_locked [3], m_wd [3];
    int cmax [3]     = '{4095, 4095, 255};
    bit sticky_p [3] = '{1'b1, 1'b0, 1'b1};
    int blo [3][3]   = '{'{100, 225, 325}, '{100, 225, 325}, '{60, 120, 200}};
    int bhi [3][3]   = '{'{150, 275, 425}, '{150, 275, 425}, '{100, 180, 255}};

    function automatic int classify(int i, int c);
        for (int b = 0; b < 3; b++)
            if (c >= blo[i][b] && c <= bhi[i][b]) return b + 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_prev[i] = 0; m_streak[i] = 0; m_code[i] = 0; m_count[i] = 0;
            m_valid[i] = 0; m_locked[i] = 0; m_wd[i] = 0;
        end
        k = 0;
    endtask

    task automatic model_close();
        int w, raw, c, d;
        bit m, was;
        w   = k / GATE;
        raw = plan_n[w] + plan_x[w];
        for (int i = 0; i < 3; i++) begin
            c   = (raw > cmax[i]) ? cmax[i] : raw;
            d   = (c > m_prev[i]) ? c - m_prev[i] : m_prev[i] - c;
            m   = (d <= 25);
            was = m_locked[i];
            m_streak[i] = m ? ((m_streak[i] < 3) ? m_streak[i] + 1 : 3) : 0;
            m_count[i]  = c;
            m_prev[i]   = c;
            m_wd[i]     = 1'b1;
            if (m_streak[i] == 3) begin
                m_code[i] = classify(i, c); m_valid[i] = 1'b1; m_locked[i] = 1'b1;
            end else begin
                m_valid[i] = 1'b0; m_locked[i] = 1'b0;
                if (was && !m && !sticky_p[i]) m_code[i] = 0;
            end
        end
    endtask

    // Mic value sampled on enabled edge kk: rises land at odd window positions
    // 3..2N+1 of the window in which they are counted, plus an optional one on the close cycle.
    function automatic logic gen(int kk);
        int t, w, p;
        t = kk + 2;
        w = (t - 1) / GATE + 1;
        p = (t - 1) % GATE;
        if (p == GATE - 1) return plan_x[w] != 0;
        if (p >= 3 && (p % 2) == 1 && p <= 2 * plan_n[w] + 1) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_cycles(int n);
        repeat (n) begin
            mic = gen(k + 1);
            @(posedge clk);
            k++;
            #1;
            if (k % GATE == 0) model_close();
            else for (int i = 0; i < 3; i++) begin m_valid[i] = 1'b0; m_wd[i] = 1'b0; end
        end
    endtask

    task automatic set_plan(int n, int x);
        plan_n[k / GATE + 1] = n;
        plan_x[k / GATE + 1] = x;
    endtask

    task automatic run_window(int n, int x);
        set_plan(n, x);
        run_cycles(GATE - k % GATE);
    endtask

    function automatic logic [17:0] act_vec(int i);
        case (i)
            0:       return {count_a, code_a, cv_a, lk_a, wd_a};
            1:       return {count_b, code_b, cv_b, lk_b, wd_b};
            default: return {4'd0, count_c, code_c, cv_c, lk_c, wd_c};
        endcase
    endfunction

    function automatic logic [17:0] exp_vec(int i);
        return {12'(m_count[i]), 3'(m_code[i]), m_valid[i], m_locked[i], m_wd[i]};
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; mic = 1'b0;
        #3;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_vec(i) !== 18'd0) begin
                errors++; $display("FAIL reset_async dut%0d: got %h want 0", i, act_vec(i));
            end
        end
        #20;
        reset = 1'b0; enable = 1'b1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_vec(i) !== exp_vec(i)) begin
                errors++; $display("FAIL reset_state dut%0d: got %h want %h", i, act_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_basic();
        for (int w = 1; w <= 5; w++) begin
            if (w == 5) begin
                set_plan(125, 0);
                run_cycles(500);
                checks++;
                if (wd_a !== 1'b0 || cv_a !== 1'b0 || count_a !== 12'd125 || code_a !== 3'd1) begin
                    errors++;
                    $display("FAIL basic_midwindow: got wd=%b cv=%b count=%0d code=%0d want 0 0 125 1",
                             wd_a, cv_a, count_a, code_a);
                end
            end
            run_window(125, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL basic w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
            if (w == 4) begin
                checks++;
                if (cv_a !== 1'b1 || code_a !== 3'd1 || count_a !== 12'd125) begin
                    errors++;
                    $display("FAIL basic_confirm: got cv=%b code=%0d count=%0d want 1 1 125", cv_a, code_a, count_a);
                end
            end
        end
    endtask

    task automatic test_band_switch();
        for (int w = 1; w <= 8; w++) begin
            run_window((w <= 4) ? 250 : 375, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL band_switch w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
            if (w == 5) begin
                checks++;
                if (lk_a !== 1'b0 || code_a !== 3'd2 || code_b !== 3'd0) begin
                    errors++;
                    $display("FAIL band_break: got lk=%b code_a=%0d code_b=%0d want 0 2 0", lk_a, code_a, code_b);
                end
            end
        end
        checks++;
        if (code_a !== 3'd3 || lk_a !== 1'b1) begin
            errors++; $display("FAIL band_relock: got code=%0d lk=%b want 3 1", code_a, lk_a);
        end
    endtask

    task automatic test_enable_low();
        set_plan(200, 0);
        run_cycles(300);
        enable = 1'b0;
        @(posedge clk);
        #1;
        model_clear();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_vec(i) !== 18'd0) begin
                errors++; $display("FAIL enable_clear dut%0d: got %h want 0", i, act_vec(i));
            end
        end
        enable = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            run_window(200, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL enable_restart w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_alternate();
        int strobes = 0;
        for (int w = 1; w <= 8; w++) begin
            run_window((w % 2 == 1) ? 125 : 250, 0);
            strobes += int'(cv_a);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL alternate w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (strobes != 0 || lk_a !== 1'b0) begin
            errors++; $display("FAIL alternate_quiet: got strobes=%0d lk=%b want 0 0", strobes, lk_a);
        end
    endtask

    task automatic test_sticky();
        for (int w = 1; w <= 5; w++) begin
            run_window((w <= 4) ? 125 : 250, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL sticky w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (code_a !== 3'd1 || code_b !== 3'd0 || cv_b !== 1'b0) begin
            errors++; $display("FAIL sticky_break: got code_a=%0d code_b=%0d cv_b=%b want 1 0 0", code_a, code_b, cv_b);
        end
    endtask

    task automatic test_out_of_band();
        for (int w = 1; w <= 8; w++) begin
            run_window((w <= 4) ? 480 : 300, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL out_of_band w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
            if (w == 4) begin
                checks++;
                if (cv_a !== 1'b1 || code_a !== 3'd0) begin
                    errors++; $display("FAIL oob_confirm: got cv=%b code=%0d want 1 0", cv_a, code_a);
                end
            end
        end
        checks++;
        if (count_c !== 8'd255 || cv_c !== 1'b1 || code_c !== 3'd3) begin
            errors++; $display("FAIL saturate: got count=%0d cv=%b code=%0d want 255 1 3", count_c, cv_c, code_c);
        end
    endtask

    task automatic test_close_edge();
        for (int w = 1; w <= 3; w++) begin
            run_window(200, (w == 2) ? 1 : 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL close_edge w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (count_a !== ((w == 2) ? 12'd201 : 12'd200)) begin
                errors++; $display("FAIL close_edge_count w%0d: got %0d want %0d", w, count_a, (w == 2) ? 201 : 200);
            end
        end
    endtask

    task automatic test_tolerance();
        int seq [6] = '{100, 125, 100, 125, 100, 126};
        for (int w = 0; w < 6; w++) begin
            run_window(seq[w], 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL tolerance w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
            if (w == 3) begin
                checks++;
                if (cv_a !== 1'b1 || lk_a !== 1'b1) begin
                    errors++; $display("FAIL tol_25_match: got cv=%b lk=%b want 1 1", cv_a, lk_a);
                end
            end
        end
        checks++;
        if (lk_a !== 1'b0 || cv_a !== 1'b0) begin
            errors++; $display("FAIL tol_26_break: got lk=%b cv=%b want 0 0", lk_a, cv_a);
        end
    endtask

    task automatic test_async_reset();
        for (int w = 1; w <= 4; w++) run_window(250, 0);
        checks++;
        if (code_a !== 3'd2 || lk_a !== 1'b1) begin
            errors++; $display("FAIL areset_prelock: got code=%0d lk=%b want 2 1", code_a, lk_a);
        end
        set_plan(250, 0);
        run_cycles(400);
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_vec(i) !== 18'd0) begin
                errors++; $display("FAIL areset_immediate dut%0d: got %h want 0", i, act_vec(i));
            end
        end
        mic = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        for (int w = 1; w <= 4; w++) begin
            run_window(250, 0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL areset_restart w%0d dut%0d: got %h want %h", w, i, act_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (cv_a !== ((w == 4) ? 1'b1 : 1'b0)) begin
                errors++; $display("FAIL areset_first_valid w%0d: got %b want %b", w, cv_a, (w == 4));
            end
        end
    endtask

    task automatic test_random();
        int n = 250;
        int x;
        for (int w = 1; w <= 12; w++) begin
            if ($urandom_range(0, 1) == 1) n = n + int'($urandom_range(0, 60)) - 30;
            else n = int'($urandom_range(30, 490));
            if (n < 30) n = 30;
            if (n > 490) n = 490;
            x = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_window(n, x);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (act_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL random w%0d n=%0d x=%0d dut%0d: got %h want %h",
                                       w, n, x, i, act_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_band_switch();
        test_enable_low();
        test_alternate();
        test_sticky();
        test_out_of_band();
        test_close_edge();
        test_tolerance();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
